// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the MIPS front end.
package mips_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] PC_STEP = 32'd4;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] pc4;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head data masked to zero while empty.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             push_data,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   do_pop_c;
   logic                   do_push_c;

   // Occupancy comes from the counter so a full queue is never mistaken for empty.
   assign do_pop_c  = pop && (count_q != '0);
   assign do_push_c = push && !flush && ((count_q < CNT_W'(DEPTH)) || do_pop_c);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left unreset; the head mask hides stale contents.
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch PC register and push/redirect control in front of a small instruction queue.
module instruction_fetch_queue
   import mips_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                    clk,
   input  logic                    reset,
   output logic [WORD_W-1:0]       imem_addr,
   input  logic [WORD_W-1:0]       imem_instr,
   input  logic                    redirect,
   input  logic [WORD_W-1:0]       redirect_pc,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORD_W-1:0]       out_instr,
   output logic [WORD_W-1:0]       out_pc4,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WORD_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  count_c;
   logic              pop_c;
   logic              push_c;
   fetch_entry_t      push_data_c;
   fetch_entry_t      head_c;

   // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
   assign pop_c  = (count_c != '0) && out_ready;
   assign push_c = !redirect && ((count_c < CNT_W'(DEPTH)) || pop_c);

   assign push_data_c.pc4   = pc_q + PC_STEP;
   assign push_data_c.instr = imem_instr;

   always_comb begin
      pc_d = pc_q;
      if (redirect)    pc_d = {redirect_pc[WORD_W-1:2], 2'b00};
      else if (push_c) pc_d = pc_q + PC_STEP;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (push_c),
      .pop       (pop_c),
      .flush     (redirect),
      .push_data (push_data_c),
      .head      (head_c),
      .count     (count_c)
   );

   assign imem_addr = pc_q;
   assign count     = count_c;
   assign out_valid = (count_c != '0);
   assign out_instr = head_c.instr;
   assign out_pc4   = head_c.pc4;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed and randomized checks of instruction_fetch_queue against a queue-based reference model.
module tb_instruction_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc4;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   // Model state: entries are {pc4, instr}, head at index 0.
   logic [63:0] m_q[$];
   logic [31:0] m_pc;

   instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_instr  (imem_instr),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc4     (out_pc4),
      .count       (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h2008_0005;
         32'h0000_0004: return 32'h2009_0003;
         default:       return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
      endcase
   endfunction

   always_comb imem_instr = imem(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pc = RESET_PC;
   endtask

   task automatic check_model();
      logic [63:0] h;
      h = (m_q.size() != 0) ? m_q[0] : 64'h0;
      chk("count",     32'(count),     32'(m_q.size()));
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("out_pc4",   out_pc4,        h[63:32]);
      chk("out_instr", out_instr,      h[31:0]);
      chk("imem_addr", imem_addr,      m_pc);
   endtask

   task automatic model_edge(input logic rdy, input logic rd, input logic [31:0] rpc);
      int  n;
      bit  popped;
      n      = m_q.size();
      popped = (n != 0) && rdy;
      if (rd) begin
         m_q.delete();
         m_pc = rpc & 32'hFFFF_FFFC;
      end else begin
         if (popped) void'(m_q.pop_front());
         if (n < DEPTH || popped) begin
            m_q.push_back({m_pc + 32'd4, imem(m_pc)});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // One clock: check at the falling edge, drive, advance DUT and model together.
   task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
      check_model();
      out_ready   = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      @(posedge clk);
      model_edge(rdy, rd, rpc);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_addr",  imem_addr, RESET_PC);
      chk("rst_instr", out_instr, 32'd0);
      chk("rst_pc4",   out_pc4,   32'd0);
      reset = 1'b0;

      // First fetches stream straight through with the consumer ready.
      step(1, 0, 0);
      chk("c1_pc4",   out_pc4,   32'h4);
      chk("c1_instr", out_instr, 32'h2008_0005);
      step(1, 0, 0);
      chk("c2_pc4",   out_pc4,   32'h8);
      chk("c2_instr", out_instr, 32'h2009_0003);
      chk("c2_count", 32'(count), 32'd1);

      // Stall until full, then drain in order while the queue stays full.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0);
         chk("fill_count", 32'(count), (i < 3) ? 32'(i + 1) : 32'd4);
      end
      chk("full_addr", imem_addr, 32'h10);
      for (int i = 0; i < 4; i++) begin
         chk("drain_pc4",  out_pc4,   32'(4 * (i + 1)));
         chk("full_count", 32'(count), 32'd4);
         chk("full_addr2", imem_addr, 32'(32'h10 + 4 * i));
         step(1, 0, 0);
      end

      // Redirect from count 3 with a misaligned target.
      do_reset();
      repeat (3) step(0, 0, 0);
      chk("pre_redir_count", 32'(count), 32'd3);
      step(1, 1, 32'h0000_0043);
      chk("redir_count", 32'(count), 32'd0);
      chk("redir_valid", 32'(out_valid), 32'd0);
      chk("redir_addr",  imem_addr, 32'h40);
      step(0, 0, 0);
      chk("redir_pc4",   out_pc4, 32'h44);

      // Address wrap at the top of memory.
      step(0, 1, 32'hFFFF_FFF8);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("wrap_pc4a", out_pc4, 32'hFFFF_FFFC);
      chk("wrap_addr", imem_addr, 32'h0);
      step(1, 0, 0);
      chk("wrap_pc4b", out_pc4, 32'h0);

      // Held redirect keeps the queue empty and reloads the PC each cycle.
      step(1, 1, 32'h0000_1000);
      step(1, 1, 32'h0000_2001);
      chk("hold_addr1", imem_addr, 32'h2000);
      step(0, 1, 32'h0000_3002);
      chk("hold_count", 32'(count), 32'd0);
      chk("hold_addr2", imem_addr, 32'h3000);

      // Reset pulsed between edges discards entries immediately.
      do_reset();
      step(0, 0, 0);
      step(0, 0, 0);
      chk("pre_rst_count", 32'(count), 32'd2);
      #1 reset = 1'b1;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_addr",  imem_addr, RESET_PC);
      #1 reset = 1'b0;
      model_reset();

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic        rd;
         logic [31:0] rpc;
         rd  = ($urandom_range(0, 9) == 0);
         rpc = $urandom;
         if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
         step(1'($urandom_range(0, 1)), rd, rpc);
      end
      check_model();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
